// File: rtl/bitstream_region_mgr_if.sv
// Bundles the header-allocation, capture-beat and id-lookup signals of the bitstream region manager.
// The master is the capture/DMA-init client and the slave is the manager.
interface bitstream_region_mgr_if #(
  parameter int unsigned ADDR_WIDTH = 34
);
  logic                  clear;
  logic                  alloc_valid;
  logic                  alloc_ready;
  logic [7:0]            alloc_id;
  logic [31:0]           alloc_size;
  logic                  alloc_ack;
  logic                  alloc_err;
  logic [ADDR_WIDTH-1:0] alloc_addr;
  logic                  abort;
  logic                  beat_valid;
  logic                  wr_active;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic                  capture_done;
  logic                  lookup_valid;
  logic [7:0]            lookup_id;
  logic                  lookup_resp_valid;
  logic                  lookup_hit;
  logic [ADDR_WIDTH-1:0] lookup_addr;
  logic [31:0]           lookup_size;

  modport master (
    output clear, alloc_valid, alloc_id, alloc_size, abort, beat_valid, lookup_valid, lookup_id,
    input  alloc_ready, alloc_ack, alloc_err, alloc_addr, wr_active, wr_addr, capture_done,
           lookup_resp_valid, lookup_hit, lookup_addr, lookup_size
  );

  modport slave (
    input  clear, alloc_valid, alloc_id, alloc_size, abort, beat_valid, lookup_valid, lookup_id,
    output alloc_ready, alloc_ack, alloc_err, alloc_addr, wr_active, wr_addr, capture_done,
           lookup_resp_valid, lookup_hit, lookup_addr, lookup_size
  );
endinterface

// File: rtl/bitstream_region_mgr.sv
// Allocates linear 64 B-aligned DDR regions for captured PR bitstreams, drives per-beat write
// addresses, and keeps the id -> {base,size,valid} table served to the DMA-init lookup path.
module bitstream_region_mgr #(
  parameter int unsigned           ADDR_WIDTH   = 34,
  parameter int unsigned           NUM_SLOTS    = 16,
  parameter logic [ADDR_WIDTH-1:0] REGION_BASE  = '0,
  parameter logic [ADDR_WIDTH:0]   REGION_LIMIT = (ADDR_WIDTH+1)'(64'h1_0000_0000)
) (
  input  logic                  m_axi_aclk,
  input  logic                  rst,
  bitstream_region_mgr_if.slave bus
);
  localparam int unsigned ID_W  = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int unsigned EXT_W = ADDR_WIDTH + 1;
  localparam int unsigned RND_W = 33;

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_COMMIT} state_t;

  state_t                state_q, state_d;
  logic [EXT_W-1:0]      alloc_ptr_q, alloc_ptr_d;
  logic [EXT_W-1:0]      end_q, end_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [ID_W-1:0]       id_q, id_d;
  logic [31:0]           size_q, size_d;
  logic                  ack_q, ack_d, err_q, err_d, done_q, done_d;
  logic [ADDR_WIDTH-1:0] alloc_addr_q, alloc_addr_d;
  logic                  accept_c, commit_c;

  logic [RND_W-1:0]      size_rnd;
  logic [EXT_W-1:0]      alloc_end;
  logic                  req_bad;

  logic                  tbl_valid [NUM_SLOTS];
  logic [ADDR_WIDTH-1:0] tbl_base  [NUM_SLOTS];
  logic [31:0]           tbl_size  [NUM_SLOTS];

  logic                  lk_valid_q, lk_hit_q;
  logic [ADDR_WIDTH-1:0] lk_addr_q;
  logic [31:0]           lk_size_q;

  // Rounded size and prospective region end, wide enough that neither can wrap
  assign size_rnd  = (RND_W'(bus.alloc_size) + RND_W'(63)) & ~RND_W'(63);
  assign alloc_end = alloc_ptr_q + EXT_W'(size_rnd);
  assign req_bad   = (32'(bus.alloc_id) >= NUM_SLOTS) || (bus.alloc_size == 32'd0) ||
                     (alloc_end > REGION_LIMIT);

  always_ff @(posedge m_axi_aclk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      alloc_ptr_q  <= EXT_W'(REGION_BASE);
      end_q        <= '0;
      base_q       <= '0;
      wr_addr_q    <= '0;
      id_q         <= '0;
      size_q       <= '0;
      ack_q        <= 1'b0;
      err_q        <= 1'b0;
      done_q       <= 1'b0;
      alloc_addr_q <= '0;
    end else begin
      state_q      <= state_d;
      alloc_ptr_q  <= alloc_ptr_d;
      end_q        <= end_d;
      base_q       <= base_d;
      wr_addr_q    <= wr_addr_d;
      id_q         <= id_d;
      size_q       <= size_d;
      ack_q        <= ack_d;
      err_q        <= err_d;
      done_q       <= done_d;
      alloc_addr_q <= alloc_addr_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    alloc_ptr_d  = alloc_ptr_q;
    end_d        = end_q;
    base_d       = base_q;
    wr_addr_d    = wr_addr_q;
    id_d         = id_q;
    size_d       = size_q;
    ack_d        = 1'b0;
    err_d        = 1'b0;
    done_d       = 1'b0;
    alloc_addr_d = alloc_addr_q;
    accept_c     = 1'b0;
    commit_c     = 1'b0;
    if (bus.clear) begin
      state_d     = S_IDLE;
      alloc_ptr_d = EXT_W'(REGION_BASE);
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.alloc_valid) begin
            if (req_bad) begin
              err_d = 1'b1;
            end else begin
              accept_c     = 1'b1;
              ack_d        = 1'b1;
              alloc_addr_d = ADDR_WIDTH'(alloc_ptr_q);
              base_d       = ADDR_WIDTH'(alloc_ptr_q);
              wr_addr_d    = ADDR_WIDTH'(alloc_ptr_q);
              end_d        = alloc_end;
              id_d         = bus.alloc_id[ID_W-1:0];
              size_d       = bus.alloc_size;
              state_d      = S_WRITE;
            end
          end
        end
        S_WRITE: begin
          // Abort wins over a coincident beat: the capture is being dropped anyway
          if (bus.abort) begin
            state_d = S_IDLE;
          end else if (bus.beat_valid) begin
            wr_addr_d = wr_addr_q + ADDR_WIDTH'(64);
            if (EXT_W'(wr_addr_q) + EXT_W'(64) == end_q) state_d = S_COMMIT;
          end
        end
        S_COMMIT: begin
          commit_c    = 1'b1;
          done_d      = 1'b1;
          alloc_ptr_d = end_q;
          state_d     = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Valid bits: cleared on grant so an id being rewritten never hits
  always_ff @(posedge m_axi_aclk) begin
    if (rst || bus.clear) begin
      for (int i = 0; i < NUM_SLOTS; i++) tbl_valid[i] <= 1'b0;
    end else if (accept_c) begin
      tbl_valid[bus.alloc_id[ID_W-1:0]] <= 1'b0;
    end else if (commit_c) begin
      tbl_valid[id_q] <= 1'b1;
    end
  end

  always_ff @(posedge m_axi_aclk) begin
    if (commit_c) begin
      tbl_base[id_q] <= base_q;
      tbl_size[id_q] <= size_q;
    end
  end

  // Registered lookup reads the pre-edge table, so a same-cycle commit is not yet visible
  always_ff @(posedge m_axi_aclk) begin
    if (rst) begin
      lk_valid_q <= 1'b0;
      lk_hit_q   <= 1'b0;
      lk_addr_q  <= '0;
      lk_size_q  <= '0;
    end else begin
      lk_valid_q <= bus.lookup_valid;
      lk_hit_q   <= 1'b0;
      lk_addr_q  <= '0;
      lk_size_q  <= '0;
      if (bus.lookup_valid && (32'(bus.lookup_id) < NUM_SLOTS) &&
          tbl_valid[bus.lookup_id[ID_W-1:0]]) begin
        lk_hit_q  <= 1'b1;
        lk_addr_q <= tbl_base[bus.lookup_id[ID_W-1:0]];
        lk_size_q <= tbl_size[bus.lookup_id[ID_W-1:0]];
      end
    end
  end

  assign bus.alloc_ready       = (state_q == S_IDLE) && !bus.clear;
  assign bus.alloc_ack         = ack_q;
  assign bus.alloc_err         = err_q;
  assign bus.alloc_addr        = alloc_addr_q;
  assign bus.wr_active         = (state_q == S_WRITE);
  assign bus.wr_addr           = wr_addr_q;
  assign bus.capture_done      = done_q;
  assign bus.lookup_resp_valid = lk_valid_q;
  assign bus.lookup_hit        = lk_hit_q;
  assign bus.lookup_addr       = lk_addr_q;
  assign bus.lookup_size       = lk_size_q;
endmodule

// File: tb/tb_bitstream_region_mgr.sv
// Directed bench for bitstream_region_mgr: allocation, beat addressing, commit, errors,
// abort, clear and lookup timing against hand-computed values.
module tb_bitstream_region_mgr;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  bitstream_region_mgr_if #(.ADDR_WIDTH(34)) bus ();

  bitstream_region_mgr #(.ADDR_WIDTH(34)) dut (
    .m_axi_aclk (clk),
    .rst        (rst),
    .bus        (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic alloc(input logic [7:0] id, input logic [31:0] size);
    bus.alloc_valid = 1'b1;
    bus.alloc_id    = id;
    bus.alloc_size  = size;
    tick();
    bus.alloc_valid = 1'b0;
  endtask

  task automatic lookup(input logic [7:0] id);
    bus.lookup_valid = 1'b1;
    bus.lookup_id    = id;
    tick();
    bus.lookup_valid = 1'b0;
  endtask

  initial begin
    bus.clear = 0; bus.alloc_valid = 0; bus.alloc_id = 0; bus.alloc_size = 0;
    bus.abort = 0; bus.beat_valid = 0; bus.lookup_valid = 0; bus.lookup_id = 0;
    tick(); tick();
    rst = 1'b0;
    #1;

    chk("rst_ready", 64'(bus.alloc_ready), 64'd1);
    chk("rst_ack", 64'(bus.alloc_ack), 64'd0);
    chk("rst_err", 64'(bus.alloc_err), 64'd0);
    chk("rst_addr", 64'(bus.alloc_addr), 64'd0);
    chk("rst_wr_active", 64'(bus.wr_active), 64'd0);
    chk("rst_wr_addr", 64'(bus.wr_addr), 64'd0);
    chk("rst_done", 64'(bus.capture_done), 64'd0);
    chk("rst_resp", 64'(bus.lookup_resp_valid), 64'd0);

    // id 3, 200 B -> 4 beats at base 0
    alloc(8'd3, 32'd200);
    chk("t1_ack", 64'(bus.alloc_ack), 64'd1);
    chk("t1_addr", 64'(bus.alloc_addr), 64'h0);
    chk("t1_active", 64'(bus.wr_active), 64'd1);
    chk("t1_ready_busy", 64'(bus.alloc_ready), 64'd0);
    for (int i = 0; i < 4; i++) begin
      chk("t1_wr_addr", 64'(bus.wr_addr), 64'(i * 64));
      bus.beat_valid = 1'b1;
      tick();
      if (i == 0) chk("t1_ack_pulse", 64'(bus.alloc_ack), 64'd0);
    end
    bus.beat_valid = 1'b0;
    chk("t1_commit_inactive", 64'(bus.wr_active), 64'd0);
    chk("t1_done_early", 64'(bus.capture_done), 64'd0);
    tick();
    chk("t1_done", 64'(bus.capture_done), 64'd1);
    chk("t1_ready_back", 64'(bus.alloc_ready), 64'd1);
    lookup(8'd3);
    chk("t1_lk_resp", 64'(bus.lookup_resp_valid), 64'd1);
    chk("t1_lk_hit", 64'(bus.lookup_hit), 64'd1);
    chk("t1_lk_addr", 64'(bus.lookup_addr), 64'h0);
    chk("t1_lk_size", 64'(bus.lookup_size), 64'd200);
    chk("t1_done_pulse", 64'(bus.capture_done), 64'd0);

    // id 5, 64 B -> base 0x100
    alloc(8'd5, 32'd64);
    chk("t2_ack", 64'(bus.alloc_ack), 64'd1);
    chk("t2_addr", 64'(bus.alloc_addr), 64'h100);
    chk("t2_wr_addr", 64'(bus.wr_addr), 64'h100);
    bus.beat_valid = 1'b1;
    tick();
    bus.beat_valid = 1'b0;
    tick();
    chk("t2_done", 64'(bus.capture_done), 64'd1);
    lookup(8'd5);
    chk("t2_lk5_hit", 64'(bus.lookup_hit), 64'd1);
    chk("t2_lk5_addr", 64'(bus.lookup_addr), 64'h100);
    chk("t2_lk5_size", 64'(bus.lookup_size), 64'd64);
    lookup(8'd4);
    chk("t2_lk4_resp", 64'(bus.lookup_resp_valid), 64'd1);
    chk("t2_lk4_hit", 64'(bus.lookup_hit), 64'd0);
    chk("t2_lk4_addr", 64'(bus.lookup_addr), 64'h0);
    chk("t2_lk4_size", 64'(bus.lookup_size), 64'd0);

    // Rejections: alloc_ptr is 0x140, so 0xFFFFFF00 B ends at 0x1_0000_0040 > limit
    alloc(8'd16, 32'd10);
    chk("t3_id_err", 64'(bus.alloc_err), 64'd1);
    chk("t3_id_ack", 64'(bus.alloc_ack), 64'd0);
    chk("t3_id_ready", 64'(bus.alloc_ready), 64'd1);
    alloc(8'd2, 32'd0);
    chk("t3_zero_err", 64'(bus.alloc_err), 64'd1);
    alloc(8'd2, 32'hFFFF_FF00);
    chk("t3_big_err", 64'(bus.alloc_err), 64'd1);
    chk("t3_big_active", 64'(bus.wr_active), 64'd0);
    tick();
    chk("t3_err_pulse", 64'(bus.alloc_err), 64'd0);
    lookup(8'd3);
    chk("t3_tbl_hit", 64'(bus.lookup_hit), 64'd1);
    chk("t3_tbl_size", 64'(bus.lookup_size), 64'd200);
    lookup(8'd16);
    chk("t3_lk16_hit", 64'(bus.lookup_hit), 64'd0);

    // Exact fit to REGION_LIMIT is accepted, then aborted
    alloc(8'd9, 32'hFFFF_FEC0);
    chk("t3_fit_ack", 64'(bus.alloc_ack), 64'd1);
    chk("t3_fit_addr", 64'(bus.alloc_addr), 64'h140);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk("t3_fit_abort", 64'(bus.wr_active), 64'd0);
    lookup(8'd9);
    chk("t3_lk9_hit", 64'(bus.lookup_hit), 64'd0);

    // id 7, 256 B, abort after 2 beats
    alloc(8'd7, 32'd256);
    chk("t4_addr", 64'(bus.alloc_addr), 64'h140);
    bus.beat_valid = 1'b1;
    tick();
    chk("t4_wr_addr1", 64'(bus.wr_addr), 64'h180);
    tick();
    bus.beat_valid = 1'b0;
    chk("t4_wr_addr2", 64'(bus.wr_addr), 64'h1C0);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk("t4_abort_idle", 64'(bus.wr_active), 64'd0);
    chk("t4_abort_ready", 64'(bus.alloc_ready), 64'd1);
    tick();
    chk("t4_no_done", 64'(bus.capture_done), 64'd0);
    lookup(8'd7);
    chk("t4_lk7_hit", 64'(bus.lookup_hit), 64'd0);
    alloc(8'd8, 32'd64);
    chk("t4_same_base", 64'(bus.alloc_addr), 64'h140);

    // clear during WRITE of id 8
    bus.clear = 1'b1;
    #1;
    chk("t5_ready_clear", 64'(bus.alloc_ready), 64'd0);
    tick();
    bus.clear = 1'b0;
    #1;
    chk("t5_idle", 64'(bus.wr_active), 64'd0);
    chk("t5_ready", 64'(bus.alloc_ready), 64'd1);
    chk("t5_no_ack", 64'(bus.alloc_ack), 64'd0);
    lookup(8'd3);
    chk("t5_lk3_hit", 64'(bus.lookup_hit), 64'd0);
    lookup(8'd5);
    chk("t5_lk5_hit", 64'(bus.lookup_hit), 64'd0);
    tick();
    chk("t5_no_done", 64'(bus.capture_done), 64'd0);

    // id 3, 100 B -> 2 beats at REGION_BASE; lookup in COMMIT cycle
    alloc(8'd3, 32'd100);
    chk("t6_addr", 64'(bus.alloc_addr), 64'h0);
    bus.beat_valid = 1'b1;
    tick();
    tick();
    bus.beat_valid = 1'b0;
    chk("t6_in_commit", 64'(bus.wr_active), 64'd0);
    bus.lookup_valid = 1'b1;
    bus.lookup_id    = 8'd3;
    tick();
    chk("t6_done", 64'(bus.capture_done), 64'd1);
    chk("t6_commit_miss", 64'(bus.lookup_hit), 64'd0);
    tick();
    bus.lookup_valid = 1'b0;
    chk("t6_after_hit", 64'(bus.lookup_hit), 64'd1);
    chk("t6_after_addr", 64'(bus.lookup_addr), 64'h0);
    chk("t6_after_size", 64'(bus.lookup_size), 64'd100);

    // Re-allocating id 3 invalidates it while in WRITE; old region not reclaimed
    alloc(8'd3, 32'd64);
    chk("t7_addr", 64'(bus.alloc_addr), 64'h80);
    lookup(8'd3);
    chk("t7_write_miss", 64'(bus.lookup_hit), 64'd0);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk("t7_abort", 64'(bus.wr_active), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
